alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu_pkg.sv | 31 +++
 rtl/alu_div.sv | 61 ++++++
 rtl/alu_mdu.sv | 176 +++++++++++++++++
 tb/tb_alu_mdu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - shared op codes and FSM state type for the ALU/MDU
package alu_mdu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DIV_FIX = 2'd2
    } state_e;

endpackage

// File: rtl/alu_div.sv
// rtl/alu_div.sv - unsigned restoring divider, one quotient bit per cycle
module alu_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    output logic             done,
    output logic [CNT_W-1:0] cnt,
    output logic [XLEN-1:0]  quotient,
    output logic [XLEN-1:0]  remainder
);

    logic            busy;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;

    // Partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits.
    assign rem_sh = {rem_q, quot_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            quot_q <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
        end else if (busy && cnt != CNT_W'(XLEN)) begin
            cnt <= cnt + CNT_W'(1);
            if (diff[XLEN]) begin
                rem_q  <= rem_sh[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end else begin
                rem_q  <= diff[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end
        end
    end

    assign done      = busy && (cnt == CNT_W'(XLEN));
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - integer ALU with inline multiplier and iterative divider
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow
);

    localparam int SH_W = $clog2(XLEN);

    state_e            state_q, state_n;
    alu_op_e           op_e;
    logic              accept, start_div, load_now, load_fix;
    logic [XLEN-1:0]   res_now, fix_res;
    logic              ovf_now;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   sum, dif;
    logic              src1_neg, src2_neg;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic              a_signed, b_signed;
    logic              div_signed, div_is_rem, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2;
    logic              neg_q_q, neg_r_q, rem_sel_q;
    logic              div_done, div_clear;
    logic [CNT_W-1:0]  div_cnt;
    logic [XLEN-1:0]   div_quot, div_rem;

    assign op_e     = alu_op_e'(op);
    assign in_ready = rst_n && (state_q == IDLE) && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign shamt    = src2[SH_W-1:0];
    assign sum      = src1 + src2;
    assign dif      = src1 - src2;
    assign src1_neg = src1[XLEN-1];
    assign src2_neg = src2[XLEN-1];

    // Sign-extend to 2*XLEN so one multiplier serves s*s, s*u and u*u.
    assign a_signed = (op_e == OP_MULH) || (op_e == OP_MULHSU);
    assign b_signed = (op_e == OP_MULH);
    assign mul_a    = {{XLEN{a_signed & src1_neg}}, src1};
    assign mul_b    = {{XLEN{b_signed & src2_neg}}, src2};
    assign prod     = mul_a * mul_b;

    assign div_signed = (op_e == OP_DIV) || (op_e == OP_REM);
    assign div_is_rem = (op_e == OP_REM) || (op_e == OP_REMU);
    assign div_zero   = (src2 == '0);
    assign div_ovf    = div_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&src2);
    assign mag1       = (div_signed && src1_neg) ? -src1 : src1;
    assign mag2       = (div_signed && src2_neg) ? -src2 : src2;

    always_comb begin
        res_now   = '0;
        ovf_now   = 1'b0;
        start_div = 1'b0;
        case (op_e)
            OP_ADD: begin
                res_now = sum;
                ovf_now = (src1_neg == src2_neg) && (sum[XLEN-1] != src1_neg);
            end
            OP_SUB: begin
                res_now = dif;
                ovf_now = (src1_neg != src2_neg) && (dif[XLEN-1] != src1_neg);
            end
            OP_SLL:    res_now = src1 << shamt;
            OP_SLT:    res_now = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            OP_SLTU:   res_now = {{(XLEN-1){1'b0}}, src1 < src2};
            OP_XOR:    res_now = src1 ^ src2;
            OP_SRL:    res_now = src1 >> shamt;
            OP_SRA:    res_now = $unsigned($signed(src1) >>> shamt);
            OP_OR:     res_now = src1 | src2;
            OP_AND:    res_now = src1 & src2;
            OP_MUL:    res_now = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:
                       res_now = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (div_zero)
                    res_now = div_is_rem ? src1 : '1;
                else if (div_ovf)
                    res_now = div_is_rem ? '0 : src1;
                else
                    start_div = 1'b1;
            end
            default: res_now = '0;
        endcase
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (accept && start_div) state_n = DIV_RUN;
            DIV_RUN: if (div_cnt == CNT_W'(XLEN - 1)) state_n = DIV_FIX;
            DIV_FIX: if (div_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (accept && start_div) begin
            neg_q_q   <= div_signed && (src1_neg ^ src2_neg);
            neg_r_q   <= div_signed && src1_neg;
            rem_sel_q <= div_is_rem;
        end
    end

    assign div_clear = flush || (state_q == DIV_FIX);

    alu_div #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (div_clear),
        .start     (accept && start_div),
        .dividend  (mag1),
        .divisor   (mag2),
        .done      (div_done),
        .cnt       (div_cnt),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    assign fix_res  = rem_sel_q ? (neg_r_q ? -div_rem : div_rem)
                                : (neg_q_q ? -div_quot : div_quot);
    assign load_now = accept && !start_div;
    assign load_fix = (state_q == DIV_FIX) && div_done;

    // Flush beats any same-cycle load; a new load beats the consumer's pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_now) begin
            out_valid <= 1'b1;
            result    <= res_now;
            overflow  <= ovf_now;
        end else if (load_fix) begin
            out_valid <= 1'b1;
            result    <= fix_res;
            overflow  <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - vector table plus scoreboard bench for alu_mdu
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      op = 5'd0;
    logic [XLEN-1:0] src1 = '0;
    logic [XLEN-1:0] src2 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            ovf;
        int              due;
        string           name;
    } exp_t;

    typedef struct {
        logic [4:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] res;
        logic            ovf;
        int              lat;
        string           name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result actual=%h required=none", result);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL %s actual=%h/%b required=%h/%b", e.name, result, overflow, e.res, e.ovf);
                end
                if (e.due >= 0) begin
                    checks++;
                    if (cyc != e.due) begin
                        errors++;
                        $display("FAIL %s_latency actual_cycle=%0d required_cycle=%0d", e.name, cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] r, input logic v, input int lat, input string name);
        vec_t t;
        t.op = o; t.a = a; t.b = b; t.res = r; t.ovf = v; t.lat = lat; t.name = name;
        vecs.push_back(t);
    endtask

    task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] r, input logic v, input int lat, input string name,
                         input bit expect_out);
        exp_t e;
        int n;
        n = 0;
        in_valid = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        #1;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept actual=timeout required=in_ready", name);
        end else if (expect_out) begin
            e.res = r; e.ovf = v; e.due = (lat < 0) ? -1 : cyc + lat; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int bad_v, bad_r, bad_rdy;

        add_vec(OP_ADD,    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1,  "add_ovf");
        add_vec(OP_SUB,    32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1,  "sub_ovf");
        add_vec(OP_SUB,    32'd5,         32'd3,         32'd2,         1'b0, 1,  "sub");
        add_vec(OP_SLL,    32'd1,         32'h0000_0021, 32'd2,         1'b0, 1,  "sll_mask");
        add_vec(OP_SRA,    32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1,  "sra");
        add_vec(OP_SRL,    32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1,  "srl");
        add_vec(OP_SLT,    32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1,  "slt");
        add_vec(OP_SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1,  "sltu");
        add_vec(OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1,  "xor");
        add_vec(OP_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1,  "and");
        add_vec(OP_OR,     32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0, 1,  "or");
        add_vec(OP_MUL,    32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9, 1'b0, 1,  "mul");
        add_vec(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1,  "mulh");
        add_vec(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1,  "mulhu");
        add_vec(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 1,  "mulhsu");
        add_vec(OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1,  "divu_zero");
        add_vec(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1,  "div_ovf");
        add_vec(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1,  "rem_ovf");
        add_vec(OP_REMU,   32'd7,         32'd0,         32'd7,         1'b0, 1,  "remu_zero");
        add_vec(5'd31,     32'h7FFF_FFFF, 32'd1,         32'd0,         1'b0, 1,  "undef_op");
        add_vec(OP_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 34, "divu");
        add_vec(OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0, 34, "remu");
        add_vec(OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34, "div_neg_divisor");
        add_vec(OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 34, "rem_pos_dividend");

        repeat (2) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        @(negedge clk);

        foreach (vecs[i])
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].lat, vecs[i].name, 1'b1);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34, "div_m7_2", 1'b1);
        bad_rdy = 0;
        for (int i = 0; i < 33; i++) begin
            #1;
            if (in_ready) bad_rdy++;
            @(negedge clk);
        end
        chk("div_busy_in_ready", bad_rdy, 0);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34, "rem_m7_2", 1'b1);
        drain();

        out_ready = 1'b0;
        issue(OP_SUB, 32'd10, 32'd3, 32'd7, 1'b0, -1, "sub_stall", 1'b1);
        bad_v = 0; bad_r = 0; bad_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (out_valid !== 1'b1) bad_v++;
            if (result !== 32'd7 || overflow !== 1'b0) bad_r++;
            if (in_ready !== 1'b0) bad_rdy++;
            @(negedge clk);
        end
        chk("stall_out_valid", bad_v, 0);
        chk("stall_result", bad_r, 0);
        chk("stall_in_ready", bad_rdy, 0);
        out_ready = 1'b1;
        issue(OP_XOR, 32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FF00, 1'b0, 1, "stream_xor0", 1'b1);
        issue(OP_OR,  32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 1, "stream_or",   1'b1);
        issue(OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1, "stream_xor1", 1'b1);
        drain();

        issue(OP_DIV, 32'd100, 32'd7, 32'd0, 1'b0, 34, "div_flushed", 1'b0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 1);
        @(negedge clk);
        issue(OP_DIV, 32'd1000, 32'd3, 32'd0, 1'b0, 34, "div_reset", 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_in_ready", in_ready, 0);
        chk("midreset_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postreset_in_ready", in_ready, 1);
        repeat (40) @(negedge clk);
        issue(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, "add_after_abort", 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
